header_link_bridge: RTL and testbench

Byte-stream bridge between the host communication link and the mining core. It assembles 80 received bytes into the 640-bit block header and issues a one-cycle `Block_Header_Valid` pulse to the miner. It latches each `Golden_Hash` reported on the one-cycle `Hash_Valid` pulse and serialises it back to the host as 32 bytes over a valid/ready handshake. It sits between the UART/byte transport and the mining wrapper, and is the producer of header/valid and the consumer of hash/valid.

---
 rtl/header_link_bridge_pkg.sv | 20 ++
 rtl/header_link_bridge_if.sv | 28 ++
 rtl/header_link_bridge_hash_tx_serializer.sv | 67 ++++++
 rtl/header_link_bridge.sv | 114 +++++++++++
 tb/tb_header_link_bridge.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/header_link_bridge_pkg.sv
// Shared constants and types for the header link bridge.
// Byte counts for the block header and the golden hash, the counter widths
// derived from them, and the state type of the hash transmit FSM.
package header_link_bridge_pkg;

    localparam int HEADER_BYTES = 80;
    localparam int HASH_BYTES   = 32;

    localparam int HEADER_BITS  = HEADER_BYTES * 8;
    localparam int HASH_BITS    = HASH_BYTES * 8;

    localparam int HEADER_CNT_W = $clog2(HEADER_BYTES);
    localparam int HASH_IDX_W   = $clog2(HASH_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/header_link_bridge_if.sv
// Host-side byte link: receive stream (no backpressure) and transmit stream
// with valid/ready handshake. The host/transport drives the master side, the
// bridge sits on the slave side.
interface header_link_bridge_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/header_link_bridge_hash_tx_serializer.sv
// hash_tx_serializer: latches a golden hash on its valid pulse and sends it
// to the host MSB byte first over a valid/ready handshake. A hash arriving
// while a transfer is in flight is dropped and flagged in a sticky overrun.
module hash_tx_serializer
    import header_link_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HASH_BITS-1:0] hash,
    input  logic                 hash_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 overrun
);

    tx_state_t             state;
    logic [HASH_BITS-1:0]  shift;
    logic [HASH_IDX_W-1:0] idx;

    // The outgoing byte is always the top of the shift register, so it holds
    // steady while the sink stalls and reads zero once the hash has drained.
    assign tx_data = shift[HASH_BITS-1 -: 8];

    // Transmit FSM: load on hash pulse, shift one byte per handshake, and
    // return to idle after the last byte is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hash_valid) begin
                        shift    <= hash;
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (hash_valid) begin
                        overrun <= 1'b1;
                    end
                    if (tx_valid && tx_ready) begin
                        shift <= {shift[HASH_BITS-9:0], 8'h00};
                        if (idx == HASH_IDX_W'(HASH_BYTES - 1)) begin
                            idx      <= '0;
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/header_link_bridge.sv
// header_link_bridge: assembles 80 received bytes into the 640-bit block
// header for the miner and returns each golden hash to the host as 32 bytes.
// Optional feature macro: LINK_TIMEOUT_EN adds an idle timer that discards a
// stalled partial header and pulses timeout_err.
module header_link_bridge
    import header_link_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    header_link_bridge_if.slave    link,
    output logic [HEADER_BITS-1:0] Block_Header,
    output logic                   Block_Header_Valid,
    input  logic [HASH_BITS-1:0]   Golden_Hash,
    input  logic                   Hash_Valid,
    output logic                   busy,
    output logic                   overrun
`ifdef LINK_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    // The 80th byte goes straight into Block_Header, so only the first 79
    // bytes need to be held while a header is being assembled.
    logic [HEADER_BITS-9:0]   assembly;
    logic [HEADER_CNT_W-1:0]  rx_count;
    logic                     timeout_hit;
    logic [7:0]               ser_tx_data;
    logic                     ser_tx_valid;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef LINK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_count;

    assign timeout_hit = !link.rx_valid && (rx_count != '0) &&
                         (idle_count == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Idle timer: counts quiet cycles while a header is partially received
    // and reports the discard with a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (link.rx_valid || (rx_count == '0) || timeout_hit) begin
                idle_count <= '0;
            end else begin
                idle_count <= idle_count + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Header assembler: shift bytes in MSB-first, publish the header and a
    // one-cycle valid pulse on the 80th byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            assembly           <= '0;
            rx_count           <= '0;
            Block_Header       <= '0;
            Block_Header_Valid <= 1'b0;
        end else begin
            Block_Header_Valid <= 1'b0;
            if (link.rx_valid) begin
                assembly <= {assembly[HEADER_BITS-17:0], link.rx_data};
                if (rx_count == HEADER_CNT_W'(HEADER_BYTES - 1)) begin
                    rx_count           <= '0;
                    Block_Header       <= {assembly, link.rx_data};
                    Block_Header_Valid <= 1'b1;
                end else begin
                    rx_count <= rx_count + 1'b1;
                end
            end else if (timeout_hit) begin
                rx_count <= '0;
            end
        end
    end

    // Mining-in-progress flag: a new header wins over a simultaneous hash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (Block_Header_Valid) begin
            busy <= 1'b1;
        end else if (Hash_Valid) begin
            busy <= 1'b0;
        end
    end

    hash_tx_serializer u_tx (
        .clk        (clk),
        .rst        (rst),
        .hash       (Golden_Hash),
        .hash_valid (Hash_Valid),
        .tx_data    (ser_tx_data),
        .tx_valid   (ser_tx_valid),
        .tx_ready   (link.tx_ready),
        .overrun    (overrun)
    );

    assign link.tx_data  = ser_tx_data;
    assign link.tx_valid = ser_tx_valid;

endmodule

// File: tb/tb_header_link_bridge.sv
// Directed self-checking bench for header_link_bridge: header assembly,
// hash transmission, backpressure, overrun, asynchronous reset mid-header,
// and partial-header handling with and without LINK_TIMEOUT_EN.
module tb_header_link_bridge;
    import header_link_bridge_pkg::*;

    localparam int TB_TIMEOUT = 100;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [HEADER_BITS-1:0] Block_Header;
    logic                   Block_Header_Valid;
    logic [HASH_BITS-1:0]   Golden_Hash;
    logic                   Hash_Valid;
    logic                   busy;
    logic                   overrun;
`ifdef LINK_TIMEOUT_EN
    logic                   timeout_err;
`endif

    header_link_bridge_if link ();

    header_link_bridge #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .link               (link),
        .Block_Header       (Block_Header),
        .Block_Header_Valid (Block_Header_Valid),
        .Golden_Hash        (Golden_Hash),
        .Hash_Valid         (Hash_Valid),
        .busy               (busy),
        .overrun            (overrun)
`ifdef LINK_TIMEOUT_EN
        ,
        .timeout_err        (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int header_pulses = 0;
    int timeout_pulses = 0;
    logic [HEADER_BITS-1:0] exp_header = '0;
    logic [HASH_BITS-1:0]   hash_a, hash_b, hash_c, hash_d;

    always @(negedge clk) begin
        if (Block_Header_Valid === 1'b1) header_pulses++;
`ifdef LINK_TIMEOUT_EN
        if (timeout_err === 1'b1) timeout_pulses++;
`endif
    end

    task automatic checkOutput(input string tag, input logic [639:0] actual,
                               input logic [639:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Sends n consecutive bytes first, first+1, ... one per cycle; the model
    // keeps the last 80 bytes sent, MSB-first. Returns in the cycle after the
    // last byte was accepted.
    task automatic applyStimulus(input logic [7:0] first, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = first + 8'(i);
            link.rx_valid = 1'b1;
            link.rx_data  = b;
            exp_header    = {exp_header[HEADER_BITS-9:0], b};
            @(negedge clk);
        end
        link.rx_valid = 1'b0;
        link.rx_data  = 8'h00;
    endtask

    // Collects one hash from the link, optionally stalling at one byte and
    // optionally pulsing a second Hash_Valid at a given byte index.
    task automatic receiveHash(input logic [255:0] exp, input int stall_at,
                               input int stall_len, input int hv_at,
                               input logic [255:0] hv_hash);
        int got = 0;
        int stalled = 0;
        int cycles = 0;
        bit injected = 1'b0;
        logic [7:0] eb;
        while (got < 32 && cycles < 200) begin
            eb = exp[255 - 8*got -: 8];
            checkOutput("tx_valid_held", link.tx_valid, 1);
            checkOutput("tx_byte", link.tx_data, eb);
            if (got == hv_at && !injected) begin
                Hash_Valid  = 1'b1;
                Golden_Hash = hv_hash;
                injected    = 1'b1;
            end
            if (got == stall_at && stalled < stall_len) begin
                link.tx_ready = 1'b0;
                stalled++;
            end else begin
                link.tx_ready = 1'b1;
                got++;
            end
            @(negedge clk);
            Hash_Valid = 1'b0;
            cycles++;
        end
        link.tx_ready = 1'b1;
        checkOutput("hash_bytes_received", got, 32);
        if (stall_at >= 0) checkOutput("stall_cycles", stalled, stall_len);
        checkOutput("tx_valid_after_hash", link.tx_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        rst           = 1'b1;
        link.rx_valid = 1'b0;
        link.rx_data  = 8'h00;
        link.tx_ready = 1'b0;
        Hash_Valid    = 1'b0;
        Golden_Hash   = '0;
        hash_a = {2{128'h00112233445566778899AABBCCDDEEFF}};
        for (int k = 0; k < 32; k++) begin
            hash_b[255 - 8*k -: 8] = 8'hC0 + 8'(k);
            hash_c[255 - 8*k -: 8] = 8'h10 + 8'(k * 7);
        end
        hash_d = ~hash_c;

        repeat (2) @(negedge clk);
        checkOutput("rst_header", Block_Header, 0);
        checkOutput("rst_header_valid", Block_Header_Valid, 0);
        checkOutput("rst_tx_data", link.tx_data, 0);
        checkOutput("rst_tx_valid", link.tx_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overrun", overrun, 0);
`ifdef LINK_TIMEOUT_EN
        checkOutput("rst_timeout_err", timeout_err, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Header assembly: bytes 0x00..0x4F back-to-back.
        header_pulses = 0;
        applyStimulus(8'h00, 80);
        checkOutput("hdr_valid_n1", Block_Header_Valid, 1);
        checkOutput("hdr_first_byte", Block_Header[639:632], 8'h00);
        checkOutput("hdr_last_byte", Block_Header[7:0], 8'h4F);
        checkOutput("hdr_byte1", Block_Header[631:624], 8'h01);
        checkOutput("hdr_full", Block_Header, exp_header);
        checkOutput("busy_at_n1", busy, 0);
        @(negedge clk);
        checkOutput("hdr_valid_n2", Block_Header_Valid, 0);
        checkOutput("busy_at_n2", busy, 1);
        checkOutput("hdr_pulse_count", header_pulses, 1);

        // Hash transmission with tx_ready held high.
        link.tx_ready = 1'b1;
        Hash_Valid    = 1'b1;
        Golden_Hash   = hash_a;
        @(negedge clk);
        Hash_Valid = 1'b0;
        checkOutput("busy_cleared", busy, 0);
        for (int k = 0; k < 32; k++) begin
            logic [3:0] nib;
            nib = 4'(k);
            checkOutput("hash_a_valid", link.tx_valid, 1);
            checkOutput("hash_a_byte", link.tx_data, {nib, nib});
            @(negedge clk);
        end
        checkOutput("hash_a_done_valid", link.tx_valid, 0);
        checkOutput("hash_a_done_busy", busy, 0);

        // Backpressure: sink stalls 5 cycles at byte 3.
        Hash_Valid  = 1'b1;
        Golden_Hash = hash_b;
        @(negedge clk);
        Hash_Valid = 1'b0;
        receiveHash(hash_b, 3, 5, -1, '0);
        checkOutput("overrun_still_clear", overrun, 0);

        // Overrun: second hash arrives at byte 10 and is dropped.
        Hash_Valid  = 1'b1;
        Golden_Hash = hash_c;
        @(negedge clk);
        Hash_Valid = 1'b0;
        receiveHash(hash_c, -1, 0, 10, hash_d);
        checkOutput("overrun_set", overrun, 1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (link.tx_valid) seen++;
            @(negedge clk);
        end
        checkOutput("no_second_transfer", seen, 0);
        checkOutput("overrun_sticky", overrun, 1);

        // Reset mid-header while a hash is stalled on the link.
        applyStimulus(8'h11, 40);
        link.tx_ready = 1'b0;
        Hash_Valid    = 1'b1;
        Golden_Hash   = hash_b;
        @(negedge clk);
        Hash_Valid = 1'b0;
        checkOutput("pre_rst_tx_valid", link.tx_valid, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_header", Block_Header, 0);
        checkOutput("async_rst_header_valid", Block_Header_Valid, 0);
        checkOutput("async_rst_tx_data", link.tx_data, 0);
        checkOutput("async_rst_tx_valid", link.tx_valid, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        link.tx_ready = 1'b1;
        @(negedge clk);
        header_pulses = 0;
        applyStimulus(8'hA0, 80);
        checkOutput("post_rst_valid", Block_Header_Valid, 1);
        checkOutput("post_rst_first_byte", Block_Header[639:632], 8'hA0);
        checkOutput("post_rst_last_byte", Block_Header[7:0], 8'hEF);
        checkOutput("post_rst_full", Block_Header, exp_header);
        @(negedge clk);
        checkOutput("post_rst_pulses", header_pulses, 1);
        checkOutput("post_rst_tx_idle", link.tx_valid, 0);

        // Partial header followed by a long idle gap.
        header_pulses  = 0;
        timeout_pulses = 0;
        applyStimulus(8'h55, 10);
`ifdef LINK_TIMEOUT_EN
        repeat (110) @(negedge clk);
        checkOutput("timeout_pulses", timeout_pulses, 1);
        checkOutput("timeout_no_header", header_pulses, 0);
        applyStimulus(8'h30, 80);
        checkOutput("timeout_next_valid", Block_Header_Valid, 1);
        checkOutput("timeout_next_first", Block_Header[639:632], 8'h30);
        checkOutput("timeout_next_full", Block_Header, exp_header);
`else
        repeat (150) @(negedge clk);
        checkOutput("hold_no_header", header_pulses, 0);
        applyStimulus(8'h60, 70);
        checkOutput("hold_valid", Block_Header_Valid, 1);
        checkOutput("hold_first_byte", Block_Header[639:632], 8'h55);
        checkOutput("hold_last_byte", Block_Header[7:0], 8'hA5);
        checkOutput("hold_full", Block_Header, exp_header);
`endif
        @(negedge clk);
        checkOutput("final_pulses", header_pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
